// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// - rx_state_e      : receive FSM state encodings (3 bits)
// - DBITS_*         : data_bits_sel encodings
// - entry offsets   : layout of a receive FIFO entry {frame_err, parity_err, data[7:0]}
// - data_bits_count : number of data bits selected by data_bits_sel
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP1     = 3'd4,
    ST_STOP2     = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } rx_state_e;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam int ENTRY_WIDTH    = 10;
  localparam int DATA_MSB       = 7;
  localparam int PARITY_ERR_BIT = 8;
  localparam int FRAME_ERR_BIT  = 9;

  function automatic logic [3:0] data_bits_count(input logic [1:0] sel);
    case (sel)
      DBITS_5: return 4'd5;
      DBITS_6: return 4'd6;
      DBITS_7: return 4'd7;
      DBITS_8: return 4'd8;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read port.
// Ports: ACLK/ARESETn clock and async active-low reset; wr_en/wr_data push
// (dropped when full); rd_en pops when non-empty, rd_data/rd_valid appear the
// following cycle (rd_data is 0 when not valid); full/empty/level status.
module sync_fifo #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    level
);

  localparam logic [PTR_WIDTH:0] LEVEL_FULL = (PTR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  wr_fire;
  logic                  rd_fire;

  assign full    = (level == LEVEL_FULL);
  assign empty   = (level == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_ff @(posedge ACLK) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      if (wr_fire && !rd_fire)      level <= level + 1'b1;
      else if (rd_fire && !wr_fire) level <= level - 1'b1;
      rd_data  <= rd_fire ? mem[rd_ptr] : '0;
      rd_valid <= rd_fire;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: two-flop synchroniser, oversample counter,
// 3-sample majority vote and per-bit strobes.
// Ports: UART_RX async serial in; rx_sample_pulse oversample tick; count_en
// lets sample_cnt run (held at 0 otherwise); rx_d1 synchronised line; vote is
// the majority value, valid while vote_point is high; baud_end marks the last
// tick of the bit.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic UART_RX,
  input  logic rx_sample_pulse,
  input  logic count_en,
  output logic rx_d1,
  output logic vote,
  output logic vote_point,
  output logic baud_end
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MID_P1 = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(OVERSAMPLE - 1);

  logic          rx_d0;
  logic [CW-1:0] sample_cnt;
  logic          samp_a;
  logic          samp_b;

  // Idle line is high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rx_d0 <= 1'b1;
      rx_d1 <= 1'b1;
    end else begin
      rx_d0 <= UART_RX;
      rx_d1 <= rx_d0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sample_cnt <= '0;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
    end else if (!count_en) begin
      sample_cnt <= '0;
    end else if (rx_sample_pulse) begin
      sample_cnt <= (sample_cnt == LAST) ? '0 : sample_cnt + 1'b1;
      if (sample_cnt == MID_M1) samp_a <= rx_d1;
      if (sample_cnt == MID)    samp_b <= rx_d1;
    end
  end

  // Third sample is taken live at the vote point.
  assign vote       = (samp_a & samp_b) | (samp_a & rx_d1) | (samp_b & rx_d1);
  assign vote_point = count_en && rx_sample_pulse && (sample_cnt == MID_P1);
  assign baud_end   = count_en && rx_sample_pulse && (sample_cnt == LAST);

endmodule

// File: rtl/uart_rx_ext.sv
// UART receive controller: 5-8 data bits, optional parity, 1/2 stop bits,
// majority-voted sampling, framing/parity error tagging, break detection,
// buffered in a FIFO with level threshold and receive timeout.
// Ports: ACLK/ARESETn; UART_RX serial in; rx_sample_pulse oversample tick;
// data_bits_sel/parity_en/parity_odd0_even1/stop_bits_2 frame format;
// rx_fifo_thr level threshold; rx_data_reg_rd read request; rx_data with
// rx_parity_err/rx_frame_err valid on rx_data_read_valid; rx_ready FIFO
// non-empty; rx_thr_reached; rx_timeout; break_det and overflow pulses.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int PTR_WIDTH     = $clog2(FIFO_DEPTH),
  parameter int TIMEOUT_BAUDS = 32
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               UART_RX,
  input  logic               rx_sample_pulse,
  input  logic [1:0]         data_bits_sel,
  input  logic               parity_en,
  input  logic               parity_odd0_even1,
  input  logic               stop_bits_2,
  input  logic [PTR_WIDTH:0] rx_fifo_thr,
  input  logic               rx_data_reg_rd,
  output logic [7:0]         rx_data,
  output logic               rx_data_read_valid,
  output logic               rx_parity_err,
  output logic               rx_frame_err,
  output logic               rx_ready,
  output logic               rx_thr_reached,
  output logic               rx_timeout,
  output logic               break_det,
  output logic               overflow
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int TW = $clog2(TIMEOUT_BAUDS + 1);
  localparam logic [CW-1:0] TICK_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] BAUDS_LAST = TW'(TIMEOUT_BAUDS - 1);
  localparam logic [TW-1:0] BAUDS_MAX  = TW'(TIMEOUT_BAUDS);

  rx_state_e state, state_n;

  logic rx_d1, vote, vote_point, baud_end;
  logic start_det, finalise, frame_err, parity_err, is_break;

  logic [1:0] cfg_sel;
  logic       cfg_par_en, cfg_even, cfg_stop2;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic       par_bit;

  logic                   fifo_wr, fifo_full, fifo_empty, fifo_rd_valid;
  logic [ENTRY_WIDTH-1:0] wr_data, rd_data;
  logic [PTR_WIDTH:0]     fifo_level, thr_eff;
  logic                   rd_fire;

  logic [CW-1:0] to_tick;
  logic [TW-1:0] to_bauds;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .ACLK            (ACLK),
    .ARESETn         (ARESETn),
    .UART_RX         (UART_RX),
    .rx_sample_pulse (rx_sample_pulse),
    .count_en        ((state != ST_IDLE) && (state != ST_WAIT_IDLE)),
    .rx_d1           (rx_d1),
    .vote            (vote),
    .vote_point      (vote_point),
    .baud_end        (baud_end)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_det = 1'b0;
    finalise  = 1'b0;
    frame_err = 1'b0;
    is_break  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_d1) begin
          start_det = 1'b1;
          state_n   = ST_START;
        end
      end
      ST_START: begin
        if (vote_point && vote) state_n = ST_IDLE;
        else if (baud_end)      state_n = ST_DATA;
      end
      ST_DATA: begin
        if (baud_end && (bit_cnt == data_bits_count(cfg_sel)))
          state_n = cfg_par_en ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (baud_end) state_n = ST_STOP1;
      end
      ST_STOP1: begin
        // A good first stop bit with two stop bits configured defers the
        // finalise to STOP2; otherwise the character closes here.
        if (vote_point && !(cfg_stop2 && vote)) begin
          finalise  = 1'b1;
          frame_err = !vote;
          is_break  = !vote && (shreg == 8'h00) && !(cfg_par_en && par_bit);
          state_n   = vote ? ST_IDLE : ST_WAIT_IDLE;
        end else if (baud_end && cfg_stop2) begin
          state_n = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (vote_point) begin
          finalise  = 1'b1;
          frame_err = !vote;
          state_n   = vote ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_d1) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Frame format is captured at the start bit so register writes mid-character
  // cannot corrupt the character being received.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cfg_sel    <= DBITS_5;
      cfg_par_en <= 1'b0;
      cfg_even   <= 1'b0;
      cfg_stop2  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
    end else if (start_det) begin
      cfg_sel    <= data_bits_sel;
      cfg_par_en <= parity_en;
      cfg_even   <= parity_odd0_even1;
      cfg_stop2  <= stop_bits_2;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
    end else if (vote_point && (state == ST_DATA)) begin
      shreg[bit_cnt[2:0]] <= vote;
      bit_cnt             <= bit_cnt + 1'b1;
    end else if (vote_point && (state == ST_PARITY)) begin
      par_bit <= vote;
    end
  end

  // Total XOR of data and parity must be 0 for even, 1 for odd.
  assign parity_err = cfg_par_en && ((^shreg) ^ par_bit ^ ~cfg_even);

  always_comb begin
    wr_data                 = '0;
    wr_data[DATA_MSB:0]     = shreg;
    wr_data[PARITY_ERR_BIT] = parity_err;
    wr_data[FRAME_ERR_BIT]  = frame_err;
  end

  assign fifo_wr   = finalise && !is_break;
  assign break_det = finalise && is_break;
  assign overflow  = fifo_wr && fifo_full;
  assign rd_fire   = rx_data_reg_rd && !fifo_empty;

  sync_fifo #(
    .DATA_WIDTH (ENTRY_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_fifo (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .wr_en    (fifo_wr),
    .wr_data  (wr_data),
    .rd_en    (rx_data_reg_rd),
    .rd_data  (rd_data),
    .rd_valid (fifo_rd_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign rx_data            = rd_data[DATA_MSB:0];
  assign rx_parity_err      = rd_data[PARITY_ERR_BIT];
  assign rx_frame_err       = rd_data[FRAME_ERR_BIT];
  assign rx_data_read_valid = fifo_rd_valid;
  assign rx_ready           = !fifo_empty;

  assign thr_eff        = (rx_fifo_thr == '0) ? {{PTR_WIDTH{1'b0}}, 1'b1} : rx_fifo_thr;
  assign rx_thr_reached = (fifo_level >= thr_eff);

  // Idle bit-times are counted only while data is waiting and nothing moves;
  // the baud count saturates so rx_timeout stays set until cleared.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      to_tick    <= '0;
      to_bauds   <= '0;
      rx_timeout <= 1'b0;
    end else if (fifo_empty || rd_fire || fifo_wr || start_det) begin
      to_tick    <= '0;
      to_bauds   <= '0;
      rx_timeout <= 1'b0;
    end else if ((state == ST_IDLE) && rx_sample_pulse) begin
      if (to_tick == TICK_LAST) begin
        to_tick <= '0;
        if (to_bauds != BAUDS_MAX)  to_bauds   <= to_bauds + 1'b1;
        if (to_bauds == BAUDS_LAST) rx_timeout <= 1'b1;
      end else begin
        to_tick <= to_tick + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: directed frames plus randomised
// characters compared against a queue-based model of the receive rules.
module tb_uart_rx_ext;

  localparam int OVERSAMPLE    = 16;
  localparam int FIFO_DEPTH    = 8;
  localparam int PTR_WIDTH     = 3;
  localparam int TIMEOUT_BAUDS = 32;
  localparam int BIT_CLKS      = 4 * OVERSAMPLE;

  logic               ACLK = 1'b0;
  logic               ARESETn;
  logic               UART_RX;
  logic               rx_sample_pulse = 1'b0;
  logic [1:0]         data_bits_sel;
  logic               parity_en, parity_odd0_even1, stop_bits_2;
  logic [PTR_WIDTH:0] rx_fifo_thr;
  logic               rx_data_reg_rd;
  logic [7:0]         rx_data;
  logic               rx_data_read_valid, rx_parity_err, rx_frame_err;
  logic               rx_ready, rx_thr_reached, rx_timeout, break_det, overflow;

  int checks = 0;
  int errors = 0;
  int break_cnt = 0;
  int ovf_cnt = 0;
  int exp_breaks = 0;
  int exp_ovf = 0;
  logic [9:0] exp_q[$];

  int cfg_nbits;
  bit cfg_par_en, cfg_even, cfg_stop2;
  logic [1:0] tick_div = 2'd0;

  uart_rx_ext #(
    .OVERSAMPLE(OVERSAMPLE), .FIFO_DEPTH(FIFO_DEPTH),
    .PTR_WIDTH(PTR_WIDTH), .TIMEOUT_BAUDS(TIMEOUT_BAUDS)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .UART_RX(UART_RX),
    .rx_sample_pulse(rx_sample_pulse), .data_bits_sel(data_bits_sel),
    .parity_en(parity_en), .parity_odd0_even1(parity_odd0_even1),
    .stop_bits_2(stop_bits_2), .rx_fifo_thr(rx_fifo_thr),
    .rx_data_reg_rd(rx_data_reg_rd), .rx_data(rx_data),
    .rx_data_read_valid(rx_data_read_valid), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_ready(rx_ready),
    .rx_thr_reached(rx_thr_reached), .rx_timeout(rx_timeout),
    .break_det(break_det), .overflow(overflow)
  );

  always #5 ACLK = ~ACLK;

  // One oversample tick every 4 clocks.
  always @(posedge ACLK) begin
    tick_div        <= tick_div + 2'd1;
    rx_sample_pulse <= (tick_div == 2'd3);
  end

  always @(posedge ACLK) begin
    if (break_det === 1'b1) break_cnt <= break_cnt + 1;
    if (overflow === 1'b1)  ovf_cnt   <= ovf_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setConfig(input int n, input bit pe, input bit ev, input bit s2);
    cfg_nbits = n; cfg_par_en = pe; cfg_even = ev; cfg_stop2 = s2;
    data_bits_sel = 2'(n - 5);
    parity_en = pe; parity_odd0_even1 = ev; stop_bits_2 = s2;
  endtask

  task automatic holdLine(input logic v, input int clocks);
    UART_RX = v;
    repeat (clocks) @(posedge ACLK);
  endtask

  // Sends one character and updates the expected-entry model.
  task automatic applyStimulus(input logic [7:0] value, input logic stop1_bit,
                               input logic stop2_bit, input bit par_flip,
                               input int glitch_idx, input int idle_bits);
    logic [7:0] data;
    int ones;
    logic pbit, perr, ferr;
    data = value;
    for (int i = cfg_nbits; i < 8; i++) data[i] = 1'b0;
    ones = $countones(data);
    pbit = ((ones % 2) == 1);
    if (!cfg_even) pbit = !pbit;
    pbit = pbit ^ par_flip;

    holdLine(1'b0, BIT_CLKS);
    for (int i = 0; i < cfg_nbits; i++) begin
      if (i == glitch_idx) begin
        holdLine(data[i], 30);
        holdLine(!data[i], 4);
        holdLine(data[i], BIT_CLKS - 34);
      end else begin
        holdLine(data[i], BIT_CLKS);
      end
    end
    if (cfg_par_en) holdLine(pbit, BIT_CLKS);
    holdLine(stop1_bit, BIT_CLKS);
    if (cfg_stop2) holdLine(stop2_bit, BIT_CLKS);
    holdLine(1'b1, idle_bits * BIT_CLKS);

    if (data == 8'h00 && !(cfg_par_en && pbit) && !stop1_bit) begin
      exp_breaks++;
    end else begin
      perr = cfg_par_en && (((ones + int'(pbit)) % 2) != (cfg_even ? 0 : 1));
      ferr = !stop1_bit || (cfg_stop2 && !stop2_bit);
      if (exp_q.size() == FIFO_DEPTH) exp_ovf++;
      else exp_q.push_back({ferr, perr, data});
    end
  endtask

  task automatic readEntry(input string tag);
    logic [9:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
    @(posedge ACLK); #1 rx_data_reg_rd = 1'b1;
    @(posedge ACLK); #1 rx_data_reg_rd = 1'b0;
    checkOutput({tag, "_valid"}, 32'(rx_data_read_valid), 32'd1);
    checkOutput({tag, "_entry"}, 32'({rx_frame_err, rx_parity_err, rx_data}), 32'(exp));
    @(posedge ACLK); #1;
    checkOutput({tag, "_valid_drop"}, 32'({rx_data_read_valid, rx_data}), 32'd0);
  endtask

  initial begin
    ARESETn = 1'b0; UART_RX = 1'b1; rx_data_reg_rd = 1'b0; rx_fifo_thr = 4'd4;
    setConfig(8, 0, 0, 0);
    repeat (5) @(posedge ACLK);
    #1;
    checkOutput("reset_outputs",
      32'({rx_data, rx_data_read_valid, rx_parity_err, rx_frame_err, rx_ready,
           rx_thr_reached, rx_timeout, break_det, overflow}), 32'd0);
    ARESETn = 1'b1;
    repeat (10) @(posedge ACLK);

    $display("[TB] 8N1 0xA5");
    applyStimulus(8'hA5, 1, 1, 0, -1, 1);
    checkOutput("a5_ready", 32'(rx_ready), 32'd1);
    readEntry("a5");
    checkOutput("a5_ready_after", 32'(rx_ready), 32'd0);

    $display("[TB] 7E2 bad parity, 5O1 good parity");
    setConfig(7, 1, 1, 1);
    applyStimulus(8'h55, 1, 1, 1, -1, 1);
    checkOutput("7e2_model", 32'(exp_q[0]), 32'h155);
    readEntry("7e2");
    setConfig(5, 1, 0, 0);
    applyStimulus(8'h1F, 1, 1, 0, -1, 1);
    readEntry("5o1");

    $display("[TB] framing error and break");
    setConfig(8, 0, 0, 0);
    applyStimulus(8'h3C, 0, 1, 0, -1, 0);
    holdLine(1'b0, 3 * BIT_CLKS);
    holdLine(1'b1, 8 * BIT_CLKS);
    readEntry("frame");
    checkOutput("frame_wait_idle", 32'(rx_ready), 32'd0);
    holdLine(1'b0, 12 * BIT_CLKS);
    holdLine(1'b1, 2 * BIT_CLKS);
    exp_breaks++;
    checkOutput("break_pulse", 32'(break_cnt), 32'(exp_breaks));
    checkOutput("break_no_entry", 32'(rx_ready), 32'd0);

    $display("[TB] glitches");
    holdLine(1'b0, 4);
    holdLine(1'b1, 2 * BIT_CLKS);
    checkOutput("glitch_1tick", 32'(rx_ready), 32'd0);
    holdLine(1'b0, 12);
    holdLine(1'b1, 2 * BIT_CLKS);
    checkOutput("glitch_3tick", 32'(rx_ready), 32'd0);
    applyStimulus(8'($urandom), 1, 1, 0, 3, 1);
    readEntry("data_glitch");

    $display("[TB] overflow and threshold");
    rx_fifo_thr = 4'd4;
    for (int k = 0; k < FIFO_DEPTH + 1; k++) begin
      applyStimulus(8'($urandom), 1, 1, 0, -1, 0);
      checkOutput("thr_level", 32'(rx_thr_reached), 32'(exp_q.size() >= 4));
    end
    holdLine(1'b1, BIT_CLKS);
    checkOutput("overflow_once", 32'(ovf_cnt), 32'd1);
    checkOutput("overflow_model", 32'(ovf_cnt), 32'(exp_ovf));
    for (int k = 0; k < FIFO_DEPTH; k++) readEntry("fifo_order");
    checkOutput("fifo_drained", 32'(rx_ready), 32'd0);

    $display("[TB] threshold zero and timeout");
    rx_fifo_thr = 4'd0;
    #1 checkOutput("thr0_empty", 32'(rx_thr_reached), 32'd0);
    applyStimulus(8'($urandom), 1, 1, 0, -1, 0);
    checkOutput("thr0_level1", 32'(rx_thr_reached), 32'd1);
    repeat (30 * BIT_CLKS) @(posedge ACLK);
    #1 checkOutput("timeout_early", 32'(rx_timeout), 32'd0);
    repeat (3 * BIT_CLKS) @(posedge ACLK);
    #1 checkOutput("timeout_set", 32'(rx_timeout), 32'd1);
    readEntry("timeout_rd");
    checkOutput("timeout_clear", 32'(rx_timeout), 32'd0);
    rx_fifo_thr = 4'd4;

    $display("[TB] randomised frames");
    for (int k = 0; k < 8; k++) begin
      setConfig(5 + int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      applyStimulus(8'($urandom), logic'($urandom_range(0, 4) != 0),
                    logic'($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0), -1, 1);
      while (exp_q.size() > 0) readEntry("random");
    end
    checkOutput("random_breaks", 32'(break_cnt), 32'(exp_breaks));
    checkOutput("random_drained", 32'(rx_ready), 32'd0);

    $display("[TB] reset mid-character");
    setConfig(8, 0, 0, 0);
    applyStimulus(8'h42, 1, 1, 0, -1, 1);
    holdLine(1'b0, BIT_CLKS + 3 * BIT_CLKS + BIT_CLKS / 2);
    ARESETn = 1'b0;
    UART_RX = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 checkOutput("midreset_outputs",
      32'({rx_data, rx_data_read_valid, rx_ready, rx_timeout, break_det, overflow}), 32'd0);
    ARESETn = 1'b1;
    exp_q.delete();
    holdLine(1'b1, 12 * BIT_CLKS);
    checkOutput("midreset_empty", 32'(rx_ready), 32'd0);
    applyStimulus(8'h81, 1, 1, 0, -1, 1);
    readEntry("after_reset");
    checkOutput("final_breaks", 32'(break_cnt), 32'(exp_breaks));
    checkOutput("final_overflow", 32'(ovf_cnt), 32'(exp_ovf));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised successor UART receive controller for the AXI-attached UART peripheral. Adds 5–8 selectable data bits, 1/2 stop bits and a configurable oversample ratio. Also adds 3-sample majority voting, true parity checking against the received parity bit, framing error, break detection, FIFO level threshold and receive timeout. Received characters and their per-character error flags are buffered in a sync_fifo read by the register block.

Parameters:
OVERSAMPLE, 16, rx_sample_pulse ticks per bit; even, >=8.
FIFO_DEPTH, 8, RX FIFO entries; power of 2.
PTR_WIDTH, $clog2(FIFO_DEPTH), FIFO pointer width.
TIMEOUT_BAUDS, 32, idle bit-times with FIFO non-empty before rx_timeout.

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
UART_RX  in  1  serial input, asynchronous
rx_sample_pulse  in  1  one-cycle oversample tick
data_bits_sel  in  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en  in  1  parity bit present
parity_odd0_even1  in  1  0=odd, 1=even parity
stop_bits_2  in  1  0=1 stop bit, 1=2 stop bits
rx_fifo_thr  in  PTR_WIDTH+1  level threshold, 1..FIFO_DEPTH
rx_data_reg_rd  in  1  read request from register block
rx_data  out  8  read data, right-justified, 0 when not valid
rx_data_read_valid  out  1  rx_data/err flags valid
rx_parity_err  out  1  parity error of the entry being read
rx_frame_err  out  1  framing error of the entry being read
rx_ready  out  1  FIFO non-empty
rx_thr_reached  out  1  FIFO level >= rx_fifo_thr
rx_timeout  out  1  receive timeout, level
break_det  out  1  one-cycle pulse on break
overflow  out  1  one-cycle pulse, character dropped

Behaviour:
- Clock and reset: ARESETn asynchronous, active-low; clock ACLK. All outputs are 0 at reset. Synchroniser flops rx_d0/rx_d1 reset to 1; FSM resets to IDLE; all counters reset to 0.
- Reset mid-character discards the partial character and clears the FIFO.
- Synchronisation: UART_RX passes through 2 flops before use (rx_d1).
- sample_cnt:
  - Counts rx_sample_pulse from 0 to OVERSAMPLE-1, then wraps.
  - Held at 0 in IDLE and WAIT_IDLE.
  - Starts counting on the first pulse after rx_d1 falls.
- Majority vote: the bit value is the majority of rx_d1 at sample_cnt = M-1, M, M+1, where M = OVERSAMPLE/2. The vote is resolved at the M+1 pulse, called the "vote point".
- Baud end: the pulse with sample_cnt == OVERSAMPLE-1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE.
  - IDLE -> START when rx_d1 == 0. data_bits_sel, parity_en, parity_odd0_even1 and stop_bits_2 are latched on this transition; changes mid-character are ignored.
  - START -> IDLE at the vote point if the vote is 1 (false start; no write). Otherwise START -> DATA at baud end.
  - DATA: shifts the voted bit in LSB-first at each vote point.
    - After N bits (N = 5..8), moves to PARITY if parity is enabled, else STOP1, at baud end.
    - Unused upper bits are 0.
  - PARITY: stores the voted bit, then -> STOP1 at baud end.
    - parity_err = (XOR of data bits ^ parity bit) != (even ? 0 : 1).
    - Forced to 0 when parity_en == 0.
  - STOP1 vote point:
    - frame_err = !vote.
    - If stop_bits_2 == 1 and vote == 1, -> STOP2 at baud end.
    - Otherwise the character is finalised at this vote point.
  - STOP2 vote point: frame_err = !vote; the character is finalised.
  - Finalise: on the same cycle, write {frame_err, parity_err, data}. Then:
    - If the final stop vote == 1 -> IDLE, which allows a start bit in the second half of the stop bit.
    - Else -> WAIT_IDLE.
  - WAIT_IDLE -> IDLE when rx_d1 == 1.
- Break:
  - Condition: all data bits, the parity bit (if enabled) and the first stop bit voted 0.
  - Response: pulse break_det for 1 cycle at finalise; no FIFO write; -> WAIT_IDLE.
- FIFO:
  - Uses sync_fifo, DATA_WIDTH=10.
  - Write when full: entry dropped, contents unchanged, overflow pulses the same cycle.
  - Read: rx_data_reg_rd with FIFO non-empty -> rx_data_read_valid, rx_data and err flags asserted for 1 cycle, the cycle after the request (sync_fifo read latency). A read request while empty is ignored.
  - Simultaneous write and read is permitted; the level is unchanged.
- rx_thr_reached: combinational compare of level (PTR_WIDTH+1 bits, 0..FIFO_DEPTH) with rx_fifo_thr. A threshold of 0 is treated as 1.
- Timeout:
  - Counts bit-times (OVERSAMPLE sample pulses) while the FSM is in IDLE, the FIFO is non-empty and no read or write occurs.
  - Any read, write or start bit clears the counter and deasserts rx_timeout.
  - rx_timeout is set when the count reaches TIMEOUT_BAUDS.
  - Cleared on FIFO empty.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings, 3-bit localparams.
  - data_bits_sel encodings.
  - Entry field offsets: data [7:0], parity_err [8], frame_err [9].
- Sub-modules:
  - Reuse the existing sync_fifo as-is.
  - One natural new sub-module: uart_rx_sampler (synchroniser, sample_cnt, majority vote, vote point and baud end strobes).

Test Plan:
- 8N1, OVERSAMPLE=16, 0xA5 -> one entry; read gives rx_data=0xA5 with both err flags 0; rx_ready falls after the read.
- 7E2, 0x55 with wrong parity bit 1 -> rx_data=0x55, rx_parity_err=1. 5O1, 0x1F correct -> rx_data=0x1F, no errors.
- 8N1, 0x3C with stop bit 0 -> rx_frame_err=1 and FSM holds WAIT_IDLE until line high. 12 bit-times of 0 -> break_det pulse, no entry written.
- 1-tick low glitch on UART_RX, and a 3-tick start-bit glitch -> no write; a single-tick glitch on a data bit is outvoted, giving the correct byte.
- 9 back-to-back characters into FIFO_DEPTH=8, no reads -> overflow pulses once on the 9th; 8 entries read back in order; rx_thr_reached=1 with rx_fifo_thr=4 at level 4.
- One character then idle -> rx_timeout asserts after 32 bit-times; rx_data_reg_rd clears it. A reset asserted mid-DATA leaves an empty FIFO and the FSM in IDLE.
